// File: rtl/pw_trigger_gen.sv
`default_nettype none
// ==========================================================================
// Module : pw_trigger_gen
// Multi-pulse trigger generator: per-pulse programmable delay and width.
// Rev    : 1.0  initial release
// ==========================================================================
module pw_trigger_gen #(
  parameter int pNUM_TRIGGER_PULSES = 8,
  parameter int pNUM_TRIGGER_WIDTH  = 4,
  parameter int pDELAY_WIDTH        = 24,
  parameter int pWIDTH_WIDTH        = 24
) (
  input  logic                                          trigger_clk,
  input  logic                                          reset_n,
  input  logic                                          I_arm,
  input  logic                                          I_trigger_enable,
  input  logic [pNUM_TRIGGER_WIDTH-1:0]                 I_num_triggers,
  input  logic [pDELAY_WIDTH*pNUM_TRIGGER_PULSES-1:0]   I_trigger_delay,
  input  logic [pWIDTH_WIDTH*pNUM_TRIGGER_PULSES-1:0]   I_trigger_width,
  input  logic                                          I_match,
  output logic                                          O_trigger,
  output logic                                          O_capture_enable_pulse,
  output logic                                          O_busy,
  output logic [pNUM_TRIGGER_WIDTH-1:0]                 O_pulse_index
);

  localparam int c_DCNT_W = pDELAY_WIDTH + 1;
  localparam int c_DVEC_W = pDELAY_WIDTH * pNUM_TRIGGER_PULSES;
  localparam int c_WVEC_W = pWIDTH_WIDTH * pNUM_TRIGGER_PULSES;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_DELAY = 2'd1;
  localparam logic [1:0] c_ST_PULSE = 2'd2;

  localparam logic [pNUM_TRIGGER_WIDTH-1:0] c_MAX_PULSES = pNUM_TRIGGER_WIDTH'(pNUM_TRIGGER_PULSES);
  localparam logic [pNUM_TRIGGER_WIDTH-1:0] c_ONE_IDX    = pNUM_TRIGGER_WIDTH'(1);
  localparam logic [pWIDTH_WIDTH-1:0]       c_ONE_W      = pWIDTH_WIDTH'(1);
  localparam logic [c_DCNT_W-1:0]           c_ONE_D      = c_DCNT_W'(1);

  logic [1:0]                    state_q, state_d;
  logic [c_DCNT_W-1:0]           dcnt_q, dcnt_d;
  logic [pWIDTH_WIDTH-1:0]       wcnt_q, wcnt_d;
  logic [pNUM_TRIGGER_WIDTH-1:0] idx_q, idx_d;
  logic [pNUM_TRIGGER_WIDTH-1:0] neff_q, neff_d;
  logic [c_DVEC_W-1:0]           delay_q, delay_d;
  logic [c_WVEC_W-1:0]           width_q, width_d;
  logic                          trig_q, trig_d;
  logic                          cap_q, cap_d;

  logic                          w_accept;
  logic [pNUM_TRIGGER_WIDTH-1:0] w_neff_in;
  logic [pDELAY_WIDTH-1:0]       w_d0;
  logic [pWIDTH_WIDTH-1:0]       w_w0;
  logic [pWIDTH_WIDTH-1:0]       w_cur_width;
  logic [pDELAY_WIDTH-1:0]       w_next_delay;

  assign w_accept = (state_q == c_ST_IDLE) && I_match && I_arm && I_trigger_enable;
  assign w_d0     = I_trigger_delay[pDELAY_WIDTH-1:0];
  assign w_w0     = I_trigger_width[pWIDTH_WIDTH-1:0];

  always_comb begin
    if (I_num_triggers == '0) begin
      w_neff_in = c_ONE_IDX;
    end else if (I_num_triggers > c_MAX_PULSES) begin
      w_neff_in = c_MAX_PULSES;
    end else begin
      w_neff_in = I_num_triggers;
    end
  end

  // Width of the current pulse and delay of the following one, from the snapshot.
  always_comb begin
    w_cur_width  = '0;
    w_next_delay = '0;
    for (int i = 0; i < pNUM_TRIGGER_PULSES; i++) begin
      if (int'(idx_q) == i) begin
        w_cur_width = width_q[i*pWIDTH_WIDTH +: pWIDTH_WIDTH];
      end
      if (int'(idx_q) + 1 == i) begin
        w_next_delay = delay_q[i*pDELAY_WIDTH +: pDELAY_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    neff_d  = neff_q;
    delay_d = delay_q;
    width_d = width_q;
    trig_d  = trig_q;
    cap_d   = 1'b0;

    case (state_q)
      c_ST_IDLE: begin
        trig_d = 1'b0;
        idx_d  = '0;
        if (w_accept) begin
          delay_d = I_trigger_delay;
          width_d = I_trigger_width;
          neff_d  = w_neff_in;
          cap_d   = 1'b1;
          // A zero first delay rises in the cycle right after acceptance.
          if (w_d0 == '0) begin
            state_d = c_ST_PULSE;
            trig_d  = 1'b1;
            wcnt_d  = (w_w0 == '0) ? c_ONE_W : w_w0;
          end else begin
            state_d = c_ST_DELAY;
            dcnt_d  = c_DCNT_W'(w_d0);
          end
        end
      end

      c_ST_DELAY: begin
        if (dcnt_q <= c_ONE_D) begin
          state_d = c_ST_PULSE;
          trig_d  = 1'b1;
          wcnt_d  = (w_cur_width == '0) ? c_ONE_W : w_cur_width;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q - c_ONE_D;
        end
      end

      c_ST_PULSE: begin
        if (wcnt_q <= c_ONE_W) begin
          trig_d = 1'b0;
          wcnt_d = '0;
          // Inter-pulse gap is delay+1 low cycles so pulses never merge.
          if ((idx_q + c_ONE_IDX) < neff_q) begin
            idx_d   = idx_q + c_ONE_IDX;
            state_d = c_ST_DELAY;
            dcnt_d  = c_DCNT_W'(w_next_delay) + c_ONE_D;
          end else begin
            idx_d   = '0;
            state_d = c_ST_IDLE;
          end
        end else begin
          wcnt_d = wcnt_q - c_ONE_W;
        end
      end

      default: begin
        state_d = c_ST_IDLE;
        trig_d  = 1'b0;
        idx_d   = '0;
      end
    endcase

    if ((state_q != c_ST_IDLE) && !I_trigger_enable) begin
      state_d = c_ST_IDLE;
      trig_d  = 1'b0;
      idx_d   = '0;
      dcnt_d  = '0;
      wcnt_d  = '0;
    end
  end

  always_ff @(posedge trigger_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= c_ST_IDLE;
      dcnt_q  <= '0;
      wcnt_q  <= '0;
      idx_q   <= '0;
      neff_q  <= '0;
      delay_q <= '0;
      width_q <= '0;
      trig_q  <= 1'b0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      neff_q  <= neff_d;
      delay_q <= delay_d;
      width_q <= width_d;
      trig_q  <= trig_d;
      cap_q   <= cap_d;
    end
  end

  assign O_trigger              = trig_q;
  assign O_capture_enable_pulse = cap_q;
  assign O_busy                 = (state_q != c_ST_IDLE);
  assign O_pulse_index          = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_pw_trigger_gen.sv
`default_nettype none
// Bench for pw_trigger_gen: randomized sequences scored against an event-level
// model (capture strobe, each pulse's rise/length/index, end of busy).
module tb_pw_trigger_gen;
  localparam int NP = 8;
  localparam int NW = 4;
  localparam int DW = 24;
  localparam int WW = 24;
  localparam int K_CAP   = 0;
  localparam int K_PULSE = 1;
  localparam int K_DONE  = 2;

  typedef struct {
    int kind;
    int cyc;
    int len;
    int idx;
  } ev_t;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 I_arm = 1'b0;
  logic                 I_trigger_enable = 1'b0;
  logic [NW-1:0]        I_num_triggers = '0;
  logic [DW*NP-1:0]     I_trigger_delay = '0;
  logic [WW*NP-1:0]     I_trigger_width = '0;
  logic                 I_match = 1'b0;
  logic                 O_trigger;
  logic                 O_capture_enable_pulse;
  logic                 O_busy;
  logic [NW-1:0]        O_pulse_index;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];
  int  cfg_n;
  int  cfg_d[NP];
  int  cfg_w[NP];

  pw_trigger_gen #(
    .pNUM_TRIGGER_PULSES(NP),
    .pNUM_TRIGGER_WIDTH (NW),
    .pDELAY_WIDTH       (DW),
    .pWIDTH_WIDTH       (WW)
  ) dut (
    .trigger_clk           (clk),
    .reset_n               (reset_n),
    .I_arm                 (I_arm),
    .I_trigger_enable      (I_trigger_enable),
    .I_num_triggers        (I_num_triggers),
    .I_trigger_delay       (I_trigger_delay),
    .I_trigger_width       (I_trigger_width),
    .I_match               (I_match),
    .O_trigger             (O_trigger),
    .O_capture_enable_pulse(O_capture_enable_pulse),
    .O_busy                (O_busy),
    .O_pulse_index         (O_pulse_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int kind, input int c, input int len, input int idx);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.len  = len;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  task automatic pop_ev(input int kind, input int c, input int len, input int idx);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event actual=kind%0d@%0d expected=none", kind, c);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", kind, e.kind);
    if (kind == e.kind) begin
      chk("event_cycle", c, e.cyc);
      if (kind == K_PULSE) begin
        chk("pulse_width", len, e.len);
        chk("pulse_index", idx, e.idx);
      end
      if (kind == K_DONE) chk("done_index", idx, e.idx);
    end
  endtask

  // Monitor: turns DUT output activity into events and scores them.
  bit prev_trig = 1'b0;
  bit prev_busy = 1'b0;
  int rise_c = 0;
  int rise_idx = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_trig = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (O_capture_enable_pulse) begin
        pop_ev(K_CAP, cyc, 0, 0);
        chk("cap_busy", O_busy, 1);
      end
      if (O_trigger && !prev_trig) begin
        rise_c   = cyc;
        rise_idx = int'(O_pulse_index);
      end
      if (!O_trigger && prev_trig) pop_ev(K_PULSE, rise_c, cyc - rise_c, rise_idx);
      if (!O_busy && prev_busy) pop_ev(K_DONE, cyc, 0, int'(O_pulse_index));
      prev_trig = O_trigger;
      prev_busy = O_busy;
    end
  end

  task automatic drive_cfg();
    I_num_triggers = NW'(cfg_n);
    for (int i = 0; i < NP; i++) begin
      I_trigger_delay[i*DW +: DW] = DW'(cfg_d[i]);
      I_trigger_width[i*WW +: WW] = WW'(cfg_w[i]);
    end
  endtask

  task automatic rand_cfg();
    cfg_n = int'($urandom_range(0, 15));
    for (int i = 0; i < NP; i++) begin
      cfg_d[i] = int'($urandom_range(0, 6));
      cfg_w[i] = int'($urandom_range(0, 5));
    end
  endtask

  task automatic scramble();
    I_num_triggers = NW'($urandom_range(0, 15));
    for (int i = 0; i < NP; i++) begin
      I_trigger_delay[i*DW +: DW] = DW'($urandom_range(0, 9));
      I_trigger_width[i*WW +: WW] = WW'($urandom_range(0, 9));
    end
  endtask

  // Issues a match with the current cfg_* values, predicts the whole event
  // stream from the pulse timing rules, then runs until the sequence ends.
  task automatic run_seq(input bit do_abort, input bit noise);
    int t, neff, c, wid, nat_end, a, e;
    int rr[NP];
    int ff[NP];
    drive_cfg();
    I_arm = 1'b1;
    I_trigger_enable = 1'b1;
    I_match = 1'b1;
    t = cyc;
    neff = (cfg_n == 0) ? 1 : ((cfg_n > NP) ? NP : cfg_n);
    c = t + 1 + cfg_d[0];
    for (int i = 0; i < NP; i++) begin
      rr[i] = 0;
      ff[i] = 0;
    end
    for (int i = 0; i < neff; i++) begin
      wid = (cfg_w[i] == 0) ? 1 : cfg_w[i];
      rr[i] = c;
      ff[i] = c + wid;
      if (i + 1 < neff) c = ff[i] + cfg_d[i+1] + 1;
    end
    nat_end = ff[neff-1];
    e = nat_end;
    a = -1;
    if (do_abort) begin
      a = t + int'($urandom_range(1, nat_end - t - 1));
      e = a + 1;
    end
    push_ev(K_CAP, t + 1, 0, 0);
    for (int i = 0; i < neff; i++) begin
      if (rr[i] < e) push_ev(K_PULSE, rr[i], ((ff[i] < e) ? ff[i] : e) - rr[i], i);
    end
    push_ev(K_DONE, e, 0, 0);
    tick();
    I_match = 1'b0;
    while (cyc < e) begin
      if (noise) begin
        I_match = ($urandom_range(0, 3) == 0);
        I_arm   = 1'($urandom_range(0, 1));
        scramble();
      end
      if (cyc == a) I_trigger_enable = 1'b0;
      tick();
    end
    I_match = 1'b0;
    I_trigger_enable = 1'b1;
    I_arm = 1'b1;
  endtask

  task automatic set_all(input int n, input int d, input int w);
    cfg_n = n;
    for (int i = 0; i < NP; i++) begin
      cfg_d[i] = d;
      cfg_w[i] = w;
    end
  endtask

  initial begin
    int t;
    #12;
    chk("rst_trigger", O_trigger, 0);
    chk("rst_cap", O_capture_enable_pulse, 0);
    chk("rst_busy", O_busy, 0);
    chk("rst_index", O_pulse_index, 0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    I_arm = 1'b1;
    I_trigger_enable = 1'b1;
    repeat (3) tick();

    // Single pulse, delay 5, width 3.
    set_all(1, 5, 3);
    run_seq(1'b0, 1'b0);
    repeat (2) tick();

    // Three pulses with distinct delays and widths.
    set_all(3, 0, 0);
    cfg_d[1] = 2; cfg_d[2] = 4;
    cfg_w[0] = 1; cfg_w[1] = 2; cfg_w[2] = 3;
    run_seq(1'b0, 1'b0);

    // Disarmed or disabled matches must not start anything.
    I_arm = 1'b0; I_match = 1'b1; tick();
    I_match = 1'b0; repeat (3) tick();
    chk("disarmed_busy", O_busy, 0);
    I_arm = 1'b1; I_trigger_enable = 1'b0; I_match = 1'b1; tick();
    I_match = 1'b0; I_trigger_enable = 1'b1; repeat (3) tick();
    chk("disabled_busy", O_busy, 0);

    // Abort during the second pulse of a four-pulse sequence, then a normal run.
    set_all(4, 2, 4);
    drive_cfg();
    I_match = 1'b1;
    t = cyc;
    push_ev(K_CAP, t + 1, 0, 0);
    push_ev(K_PULSE, t + 3, 4, 0);
    push_ev(K_PULSE, t + 10, 2, 1);
    push_ev(K_DONE, t + 12, 0, 0);
    tick();
    I_match = 1'b0;
    while (cyc < t + 11) tick();
    I_trigger_enable = 1'b0;
    tick();
    chk("abort_trigger", O_trigger, 0);
    chk("abort_index", O_pulse_index, 0);
    I_trigger_enable = 1'b1;
    tick();
    set_all(2, 1, 2);
    run_seq(1'b0, 1'b1);

    // Count clamping and zero width.
    set_all(0, 1, 2);
    run_seq(1'b0, 1'b0);
    set_all(15, 0, 1);
    run_seq(1'b0, 1'b0);
    set_all(3, 1, 0);
    run_seq(1'b0, 1'b1);

    // Long first delay exercising upper counter bits.
    set_all(1, 0, 2);
    cfg_d[0] = 32771;
    run_seq(1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      rand_cfg();
      if ($urandom_range(0, 4) == 0) begin
        I_arm = 1'($urandom_range(0, 1));
        I_trigger_enable = ~I_arm;
        I_match = 1'b1;
        tick();
        I_match = 1'b0;
        I_arm = 1'b1;
        I_trigger_enable = 1'b1;
      end
      run_seq($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Asynchronous reset in the middle of a pulse.
    set_all(2, 1, 10);
    drive_cfg();
    I_match = 1'b1;
    t = cyc;
    push_ev(K_CAP, t + 1, 0, 0);
    tick();
    I_match = 1'b0;
    repeat (4) tick();
    chk("pre_reset_trigger", O_trigger, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_trigger", O_trigger, 0);
    chk("async_rst_busy", O_busy, 0);
    chk("async_rst_index", O_pulse_index, 0);
    chk("async_rst_cap", O_capture_enable_pulse, 0);
    exp_q.delete();
    @(negedge clk);
    #1 reset_n = 1'b1;
    tick();
    set_all(2, 3, 2);
    run_seq(1'b0, 1'b0);

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
